// File: rtl/hdmi_hs_pkg.sv
// Shared definitions for the HDMI frame handshake: FSM encoding,
// Avalon register map and STATUS bit layout.
package hdmi_hs_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_SCAN  = 2'd2,
      ST_DONE  = 2'd3
   } hs_state_t;

   localparam logic [1:0] ADDR_STATUS      = 2'd0;
   localparam logic [1:0] ADDR_FRAME_COUNT = 2'd1;
   localparam logic [1:0] ADDR_IRQ_MASK    = 2'd2;
   localparam logic [1:0] ADDR_LINE_COUNT  = 2'd3;

   localparam int unsigned STAT_ACTIVE_BIT   = 0;
   localparam int unsigned STAT_STATE_LSB    = 1;
   localparam int unsigned STAT_STATE_MSB    = 2;
   localparam int unsigned STAT_IRQ_BIT      = 3;
   localparam int unsigned STAT_UNDERRUN_BIT = 4;

endpackage

// File: rtl/hdmi_hs_edge_det.sv
// Rising-edge detector: one prev flop, combinational rise output.
// prev resets low, so a level already high at reset release reads as a rise.
module hdmi_hs_edge_det (
   input  logic clk,
   input  logic reset_n,
   input  logic sig,
   output logic rise
);

   logic prev;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev <= 1'b0;
      end else begin
         prev <= sig;
      end
   end

   assign rise = sig & ~prev;

endmodule

// File: rtl/hdmi_frame_handshake.sv
// Turns the HPS ready level into one vsync-aligned scan-out transaction,
// counts consumed lines and raises a maskable completion interrupt.
module hdmi_frame_handshake
   import hdmi_hs_pkg::*;
#(
   parameter int LINES_PER_FRAME = 480,
   parameter int LINE_W          = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ready_in,
   input  logic        vsync_in,
   input  logic        line_done,
   output logic        frame_start,
   output logic        scan_active,
   output logic        irq,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata
);

   localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES_PER_FRAME - 1);
   localparam logic [LINE_W-1:0] ONE       = LINE_W'(1);

   hs_state_t         state;
   logic [LINE_W-1:0] line_count;
   logic [LINE_W-1:0] frame_count;
   logic              irq_pending;
   logic              underrun;
   logic              irq_mask;
   logic              ready_rise;
   logic              vsync_rise;
   logic              wr_en;
   logic              wr_status;
   logic              wr_fcount;
   logic              wr_mask;
   logic              last_line;
   logic              unused_wdata;

   hdmi_hs_edge_det u_ready_edge (
      .clk     (clk),
      .reset_n (reset_n),
      .sig     (ready_in),
      .rise    (ready_rise)
   );

   hdmi_hs_edge_det u_vsync_edge (
      .clk     (clk),
      .reset_n (reset_n),
      .sig     (vsync_in),
      .rise    (vsync_rise)
   );

   assign wr_en     = chipselect & ~write_n;
   assign wr_status = wr_en & (address == ADDR_STATUS);
   assign wr_fcount = wr_en & (address == ADDR_FRAME_COUNT);
   assign wr_mask   = wr_en & (address == ADDR_IRQ_MASK);
   assign last_line = line_done & (line_count == LAST_LINE);
   assign irq       = irq_pending & irq_mask;

   assign unused_wdata = ^{writedata[31:5], writedata[2:1]};

   // Register clears are applied first so FSM-driven sets later in the block win.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         frame_start <= 1'b0;
         scan_active <= 1'b0;
         line_count  <= '0;
         frame_count <= '0;
         irq_pending <= 1'b0;
         underrun    <= 1'b0;
         irq_mask    <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         if (wr_status && writedata[STAT_IRQ_BIT])      irq_pending <= 1'b0;
         if (wr_status && writedata[STAT_UNDERRUN_BIT]) underrun    <= 1'b0;
         if (wr_fcount) frame_count <= '0;
         if (wr_mask)   irq_mask    <= writedata[0];

         case (state)
            ST_IDLE: begin
               if (ready_rise) state <= ST_ARMED;
            end
            ST_ARMED: begin
               if (!ready_in) begin
                  state <= ST_IDLE;
               end else if (vsync_rise) begin
                  state       <= ST_SCAN;
                  frame_start <= 1'b1;
                  scan_active <= 1'b1;
                  line_count  <= '0;
               end
            end
            ST_SCAN: begin
               if (line_done) line_count <= line_count + ONE;
               if (last_line) begin
                  state       <= ST_DONE;
                  scan_active <= 1'b0;
                  irq_pending <= 1'b1;
                  frame_count <= wr_fcount ? ONE : frame_count + ONE;
               end else if (vsync_rise) begin
                  state       <= ST_DONE;
                  scan_active <= 1'b0;
                  underrun    <= 1'b1;
               end
            end
            ST_DONE: begin
               if (!ready_in) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_STATUS: begin
            readdata[STAT_ACTIVE_BIT]                = scan_active;
            readdata[STAT_STATE_MSB:STAT_STATE_LSB]  = state;
            readdata[STAT_IRQ_BIT]                   = irq_pending;
            readdata[STAT_UNDERRUN_BIT]              = underrun;
         end
         ADDR_FRAME_COUNT: readdata = 32'(frame_count);
         ADDR_IRQ_MASK:    readdata[0] = irq_mask;
         ADDR_LINE_COUNT:  readdata = 32'(line_count);
         default:          readdata = '0;
      endcase
   end

endmodule

// File: tb/tb_hdmi_frame_handshake.sv
// Bench for hdmi_frame_handshake: directed handshake scenarios plus random
// traffic, all checked against a transaction-level reference model.
module tb_hdmi_frame_handshake;

   localparam int LPF = 4;

   logic        clk;
   logic        reset_n;
   logic        ready_in;
   logic        vsync_in;
   logic        line_done;
   logic        frame_start;
   logic        scan_active;
   logic        irq;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model: phase 0 idle, 1 armed, 2 scanning, 3 done
   int m_phase, m_lines, m_frames;
   bit m_pend, m_under, m_mask, m_fs, m_prev_r, m_prev_v;

   hdmi_frame_handshake #(.LINES_PER_FRAME(LPF), .LINE_W(16)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .ready_in    (ready_in),
      .vsync_in    (vsync_in),
      .line_done   (line_done),
      .frame_start (frame_start),
      .scan_active (scan_active),
      .irq         (irq),
      .address     (address),
      .chipselect  (chipselect),
      .write_n     (write_n),
      .writedata   (writedata),
      .readdata    (readdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_lines = 0; m_frames = 0;
      m_pend = 0; m_under = 0; m_mask = 0; m_fs = 0;
      m_prev_r = 0; m_prev_v = 0;
   endtask

   task automatic model_step(input bit r, input bit v, input bit ld, input bit cs,
                             input bit wn, input bit [1:0] a, input bit [31:0] wd);
      bit rr, vr, wr;
      rr = r && !m_prev_r;
      vr = v && !m_prev_v;
      wr = cs && !wn;
      m_fs = 0;
      if (wr) begin
         if (a == 2'd0) begin
            if (wd[3]) m_pend = 0;
            if (wd[4]) m_under = 0;
         end else if (a == 2'd1) begin
            m_frames = 0;
         end else if (a == 2'd2) begin
            m_mask = wd[0];
         end
      end
      if (m_phase == 0) begin
         if (rr) m_phase = 1;
      end else if (m_phase == 1) begin
         if (!r) m_phase = 0;
         else if (vr) begin m_phase = 2; m_fs = 1; m_lines = 0; end
      end else if (m_phase == 2) begin
         if (ld) begin
            m_lines = (m_lines + 1) % 65536;
            if (m_lines == LPF) begin
               m_phase = 3; m_pend = 1; m_frames = (m_frames + 1) % 65536;
            end
         end
         if (m_phase == 2 && vr) begin m_phase = 3; m_under = 1; end
      end else begin
         if (!r) m_phase = 0;
      end
      m_prev_r = r;
      m_prev_v = v;
   endtask

   function automatic logic [31:0] model_read(input logic [1:0] a);
      case (a)
         2'd0:    return 32'((m_phase == 2 ? 1 : 0) | (m_phase << 1) | (int'(m_pend) << 3) | (int'(m_under) << 4));
         2'd1:    return 32'(m_frames);
         2'd2:    return {31'b0, m_mask};
         default: return 32'(m_lines);
      endcase
   endfunction

   task automatic compare_all();
      check("frame_start", {31'b0, frame_start}, {31'b0, m_fs});
      check("scan_active", {31'b0, scan_active}, (m_phase == 2) ? 32'd1 : 32'd0);
      check("irq",         {31'b0, irq},         {31'b0, m_pend & m_mask});
      check("readdata",    readdata,             model_read(address));
   endtask

   // Read one register at the current (negedge) time without advancing the clock.
   task automatic peek(input string tag, input logic [1:0] a, input logic [31:0] exp);
      address = a;
      #1;
      check(tag, readdata, exp);
      check({tag, "_model"}, readdata, model_read(a));
   endtask

   // Entered at a negedge: drive, take one posedge, compare at the next negedge.
   task automatic cycle(input bit r, input bit v, input bit ld, input bit cs,
                        input bit [1:0] a, input bit [31:0] wd);
      ready_in = r; vsync_in = v; line_done = ld;
      chipselect = cs; write_n = !cs; address = a; writedata = wd;
      @(posedge clk);
      model_step(r, v, ld, cs, !cs, a, wd);
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
      compare_all();
   endtask

   task automatic do_reset(input bit r);
      reset_n = 1'b0; ready_in = r; vsync_in = 1'b0; line_done = 1'b0;
      chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = '0;
      model_reset();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      compare_all();
   endtask

   initial begin
      bit r, v;
      model_reset();
      @(negedge clk);

      // reset with ready high arms at the first edge
      do_reset(1'b1);
      peek("rst_status", 2'd0, 32'h0);
      peek("rst_fcount", 2'd1, 32'h0);
      peek("rst_lcount", 2'd3, 32'h0);
      cycle(1, 0, 0, 0, 2'd0, 0);
      peek("armed_status", 2'd0, 32'h2);
      cycle(1, 1, 0, 0, 2'd0, 0);
      check("fs_pulse", {31'b0, frame_start}, 32'd1);
      peek("scan_status", 2'd0, 32'h5);
      cycle(1, 1, 0, 1, 2'd2, 32'h1);
      check("fs_single", {31'b0, frame_start}, 32'd0);

      // full frame with interrupt enabled
      repeat (LPF) cycle(1, 0, 1, 0, 2'd0, 0);
      check("irq_done", {31'b0, irq}, 32'd1);
      peek("done_status", 2'd0, 32'hE);
      peek("done_fcount", 2'd1, 32'h1);
      cycle(1, 0, 0, 1, 2'd0, 32'h8);
      check("irq_cleared", {31'b0, irq}, 32'd0);

      // underrun after 2 of 4 lines
      cycle(0, 0, 0, 0, 2'd0, 0);
      cycle(1, 0, 0, 0, 2'd0, 0);
      cycle(1, 1, 0, 0, 2'd0, 0);
      cycle(1, 0, 1, 0, 2'd0, 0);
      cycle(1, 0, 1, 0, 2'd0, 0);
      cycle(1, 1, 0, 0, 2'd0, 0);
      peek("underrun_status", 2'd0, 32'h16);
      peek("underrun_fcount", 2'd1, 32'h1);

      // abort beats vsync in ARMED
      cycle(0, 0, 0, 0, 2'd0, 0);
      cycle(1, 0, 0, 0, 2'd0, 0);
      cycle(0, 1, 0, 0, 2'd0, 0);
      check("abort_no_fs", {31'b0, frame_start}, 32'd0);
      peek("abort_status", 2'd0, 32'h10);
      cycle(0, 0, 0, 1, 2'd0, 32'h18);

      // final line coincides with W1C of irq_pending
      cycle(1, 0, 0, 0, 2'd0, 0);
      cycle(1, 1, 0, 0, 2'd0, 0);
      repeat (LPF - 1) cycle(1, 0, 1, 0, 2'd0, 0);
      cycle(1, 0, 1, 1, 2'd0, 32'h8);
      peek("set_wins_status", 2'd0, 32'hE);

      // final line + vsync rise + FRAME_COUNT clear in one cycle
      cycle(0, 0, 0, 1, 2'd0, 32'h8);
      cycle(1, 0, 0, 0, 2'd0, 0);
      cycle(1, 1, 0, 0, 2'd0, 0);
      cycle(1, 0, 0, 0, 2'd0, 0);
      repeat (LPF - 1) cycle(1, 0, 1, 0, 2'd0, 0);
      cycle(1, 1, 1, 1, 2'd1, 32'hFFFF_FFFF);
      peek("inc_clr_fcount", 2'd1, 32'h1);
      peek("no_underrun", 2'd0, 32'hE);

      // async reset mid-SCAN, release with ready low
      cycle(0, 0, 0, 0, 2'd0, 0);
      cycle(1, 0, 0, 0, 2'd0, 0);
      cycle(1, 1, 0, 0, 2'd0, 0);
      cycle(1, 0, 1, 0, 2'd3, 0);
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      check("rst_fs",     {31'b0, frame_start}, 32'd0);
      check("rst_active", {31'b0, scan_active}, 32'd0);
      check("rst_irq",    {31'b0, irq},         32'd0);
      check("rst_lines",  readdata,             32'd0);
      ready_in = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cycle(0, (i % 2) == 1, 0, 0, 2'd0, 0);
         check("no_fs_idle", {31'b0, frame_start}, 32'd0);
      end
      cycle(1, 0, 0, 0, 2'd0, 0);
      cycle(1, 1, 0, 0, 2'd0, 0);
      check("fs_after_rearm", {31'b0, frame_start}, 32'd1);

      // random traffic
      r = 1;
      for (int i = 0; i < 3000; i++) begin
         if (i % 700 == 699) do_reset(1'($urandom_range(0, 1)));
         if ($urandom_range(0, 15) == 0) r = !r;
         v = ($urandom_range(0, 7) == 0);
         cycle(r, v, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
               2'($urandom_range(0, 3)), $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hdmi_frame_handshake.md
# hdmi_frame_handshake

Downstream consumer of the HPS-written HDMI "ready" PIO bit. Turns the level-style `ready_in` into one frame-synchronous scan-out transaction: arms on a ready rising edge, starts on the next vsync, counts consumed lines, then raises a maskable interrupt. It sits between the PIO output and the HDMI scan-out/DMA reader. It exposes a small Avalon-MM slave, in the same zero-wait-read style as the PIO, for status, frame count and IRQ control.

## Interface
Parameters:
- `LINES_PER_FRAME`, default 480: active lines per frame; legal range 1..65535.
- `LINE_W`, default 16: width of the line counter and the frame counter.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  single system clock; all inputs are synchronous to it.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ready_in`  in  1  level from the HDMI ready PIO `out_port`.
- `vsync_in`  in  1  active-high vertical sync from the video timing generator.
- `line_done`  in  1  one-cycle pulse per active line consumed by scan-out.
- `frame_start`  out  1  one-cycle pulse to the scan-out DMA.
- `scan_active`  out  1  high while in SCAN.
- `irq`  out  1  `irq_pending & irq_mask`.
- `address`  in  2  Avalon register select.
- `chipselect`  in  1  Avalon select.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data.
- `readdata`  out  32  combinational read data; zero wait states.

## Operation
- Edge detection:
  - `ready_in` and `vsync_in` are each registered into a prev flop; both prev flops reset to 0.
  - A rise is `in & ~prev`.
  - Consequence: a `ready_in` already high at reset release counts as a rise.
- FSM states: IDLE=0, ARMED=1, SCAN=2, DONE=3.
  - IDLE: on a ready rise, go to ARMED.
  - ARMED:
    - `ready_in` low: go to IDLE (abort). Abort wins over a vsync rise in the same cycle.
    - Otherwise, on a vsync rise: go to SCAN, pulse `frame_start`, clear the line counter.
  - SCAN:
    - Each `line_done` increments the line counter.
    - `line_done` while count == `LINES_PER_FRAME-1`: go to DONE, set `irq_pending`, increment `frame_count`.
    - A vsync rise before completion: set `underrun`, go to DONE, leave `irq_pending` unchanged, do not increment `frame_count`.
    - A vsync rise and the final `line_done` in the same cycle count as completion. No underrun.
    - `ready_in` is ignored in SCAN.
  - DONE: when `ready_in` is low, go to IDLE. HPS must drop ready and raise it again to re-arm.
- Registers:
  - addr 0, STATUS:
    - Read: bit0 `scan_active`, bits2:1 state, bit3 `irq_pending`, bit4 `underrun`.
    - Write: 1 to bit3 or bit4 clears that bit (W1C).
  - addr 1, FRAME_COUNT: read gives the count zero-extended. Any write clears it. The count wraps modulo 2^`LINE_W`.
  - addr 2, IRQ_MASK: bit0, read/write.
  - addr 3, LINE_COUNT: read-only.
- Reads are not gated by `chipselect`, matching the PIO behaviour.
- Same-cycle conflicts:
  - Set and W1C clear of a sticky bit: set wins.
  - Increment and write-clear of FRAME_COUNT: the result is 1.
- Reset values: `frame_start`=0, `scan_active`=0, `irq`=0, state=IDLE, all counters 0, `irq_mask`=0, `underrun`=0, `irq_pending`=0. `readdata` then reads all zero except LINE_COUNT/FRAME_COUNT, which are also 0.

## Timing
- `frame_start`:
  - Registered. It is high for exactly the one cycle following the edge at which `vsync_in`=1 with prev=0 in ARMED.
  - `scan_active` rises at that same edge.
- Completion:
  - The final `line_done` sampled at edge N gives state=DONE, `irq_pending`=1 and the incremented `frame_count`, all visible after edge N.
  - `irq` follows one gate later, combinationally.
- Latency from a `ready_in` rise to ARMED is 1 cycle.
- Register writes take effect at the write edge. Readdata reflects register state combinationally.
- Reset asserted mid-SCAN forces all outputs to their reset values immediately. No `frame_start` follows reset unless the full ready→vsync sequence repeats.

## Structure
- Package `hdmi_hs_pkg` holds:
  - the state encoding (2-bit enum, values above);
  - register address constants;
  - STATUS bit positions.
- Sub-module `hdmi_hs_edge_det` (prev flop plus rise output, async active-low reset), instantiated for `ready_in` and for `vsync_in`.
- The FSM, counters and register file stay in the top module.

## Test plan
- Reset with `ready_in`=1 → ARMED at the first edge. A vsync rise → exactly one `frame_start` cycle, STATUS reads 0x5 (SCAN, `scan_active`=1).
- `LINES_PER_FRAME`=4, `irq_mask`=1: 4 `line_done` pulses → DONE, `irq`=1, FRAME_COUNT=1. Write 0x8 to STATUS → `irq`=0.
- In SCAN after 2 of 4 lines, a vsync rise → `underrun`=1, `irq_pending`=0, FRAME_COUNT unchanged, state DONE.
- In ARMED, `ready_in` falls and vsync rises in the same cycle → IDLE, no `frame_start`.
- Final `line_done` coincides with a STATUS W1C of bit3 → `irq_pending` stays 1. FRAME_COUNT write-clear on an increment cycle → reads 1.
- `reset_n` asserted mid-SCAN, then released with `ready_in`=0 → all outputs 0, IDLE. No `frame_start` on later vsyncs until `ready_in` rises.
